// File: rtl/mem_bank_2r1w.sv
// -----------------------------------------------------------------------------
// mem_bank_2r1w
//   Flip-flop register-file bank: DEPTH words of WIDTH bits with one
//   synchronous write port and two independent registered read ports.
//   Each read port returns data exactly one cycle after its request, with a
//   one-cycle valid strobe. A read that hits the word being written in the
//   same cycle returns either the new data (BYPASS=1) or the old contents
//   (BYPASS=0). Addresses at or beyond DEPTH are out of range: writes there
//   are dropped, and reads there return zero with a valid strobe.
//
// Parameters
//   WIDTH   data word width in bits (>=1)
//   DEPTH   number of words (>=2, any value)
//   AW      address width, defaults to $clog2(DEPTH)
//   BYPASS  1 = write-first read-during-write, 0 = read-first
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset; clears array and outputs
//   we       in   1      write enable
//   waddr    in   AW     write address
//   wdata    in   WIDTH  write data
//   re0      in   1      read request, port 0
//   raddr0   in   AW     read address, port 0
//   rdata0   out  WIDTH  registered read data, port 0
//   rvalid0  out  1      read data valid, port 0
//   re1      in   1      read request, port 1
//   raddr1   in   AW     read address, port 1
//   rdata1   out  WIDTH  registered read data, port 1
//   rvalid1  out  1      read data valid, port 1
// -----------------------------------------------------------------------------
module mem_bank_2r1w #(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re0,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    output logic             rvalid0,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1
);

    // DEPTH held in AW+1 bits so the range check is a plain unsigned compare
    // that still works when DEPTH is an exact power of two.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             rvalid0_q;
    logic             rvalid1_q;
    logic             wr_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Word returned to a read port for address a this cycle. Out-of-range
    // reads yield zero. The bypass compare only matters once a is known to be
    // in range, so a dropped (out-of-range) write can never be forwarded.
    function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] a);
        logic [WIDTH-1:0] w;
        w = '0;
        if (in_range(a)) begin
            if ((BYPASS != 0) && we && (waddr == a)) begin
                w = wdata;
            end else begin
                w = mem_q[a];
            end
        end
        return w;
    endfunction

    assign wr_ok = we && in_range(waddr);

    // Storage array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports: idle ports hold their last data so the bus does not toggle.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (re0) begin
            rdata0_d = read_word(raddr0);
        end
        if (re1) begin
            rdata1_d = read_word(raddr1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= re0;
            rvalid1_q <= re1;
        end
    end

    assign rdata0  = rdata0_q;
    assign rvalid0 = rvalid0_q;
    assign rdata1  = rdata1_q;
    assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_mem_bank_2r1w.sv
// Two banks share one stimulus stream: unit 0 is 64 words write-first,
// unit 1 is 40 words read-first (addresses 40..63 are out of range there).
module tb_mem_bank_2r1w;

    localparam int W  = 20;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          re_s   [2];
    logic [AW-1:0] ra_s   [2];
    logic [W-1:0]  rd     [4];   // index = unit*2 + port
    logic          rv     [4];

    always #5 clk = ~clk;

    mem_bank_2r1w #(.WIDTH(W), .DEPTH(64), .AW(AW), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re_s[0]), .raddr0(ra_s[0]), .rdata0(rd[0]), .rvalid0(rv[0]),
        .re1(re_s[1]), .raddr1(ra_s[1]), .rdata1(rd[1]), .rvalid1(rv[1])
    );

    mem_bank_2r1w #(.WIDTH(W), .DEPTH(40), .AW(AW), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re_s[0]), .raddr0(ra_s[0]), .rdata0(rd[2]), .rvalid0(rv[2]),
        .re1(re_s[1]), .raddr1(ra_s[1]), .rdata1(rd[3]), .rvalid1(rv[3])
    );

    // ---------------- reference model ----------------
    logic [W-1:0] mem_m [2][64];
    logic [W-1:0] expq  [4][$];
    logic [W-1:0] hold  [4];
    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    function automatic int dep_of(input int k);
        return (k == 0) ? 64 : 40;
    endfunction

    function automatic bit byp_of(input int k);
        return (k == 0);
    endfunction

    function automatic logic [W-1:0] ref_read(input int k, input int a);
        if (a >= dep_of(k)) return '0;
        if (byp_of(k) && we && (int'(waddr) == a)) return wdata;
        return mem_m[k][a];
    endfunction

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) mem_m[k][i] = '0;
        for (int j = 0; j < 4; j++) hold[j] = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 64; i++) mem_m[k][i] = '0;
            for (int j = 0; j < 4; j++) begin
                hold[j] = '0;
                expq[j].delete();
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (re_s[p]) begin
                        logic [W-1:0] e;
                        e = ref_read(k, int'(ra_s[p]));
                        expq[k*2+p].push_back(e);
                        hold[k*2+p] = e;
                    end
                end
                if (we && (int'(waddr) < dep_of(k))) mem_m[k][waddr] = wdata;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            for (int j = 0; j < 4; j++) begin
                if (rv[j]) begin
                    vectors++;
                    if (expq[j].size() == 0) begin
                        miscompares++;
                        $display("FAIL rvalid_u%0d_p%0d: got rvalid=1 rdata=%h, required no response pending",
                                 j/2, j%2, rd[j]);
                    end else begin
                        logic [W-1:0] e;
                        e = expq[j].pop_front();
                        if (rd[j] !== e) begin
                            miscompares++;
                            $display("FAIL rdata_u%0d_p%0d: got %h, required %h at %0t",
                                     j/2, j%2, rd[j], e, $time);
                        end
                    end
                end else begin
                    vectors++;
                    if (expq[j].size() != 0) begin
                        miscompares++;
                        $display("FAIL rvalid_u%0d_p%0d: got rvalid=%b, required 1 (expected data %h)",
                                 j/2, j%2, rv[j], expq[j].pop_front());
                    end else if (rd[j] !== hold[j]) begin
                        miscompares++;
                        $display("FAIL rdata_hold_u%0d_p%0d: got %h, required %h at %0t",
                                 j/2, j%2, rd[j], hold[j], $time);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic w, input int wa, input int wd,
                       input logic r0, input int a0, input logic r1, input int a1);
        @(negedge clk);
        rst     = r;
        we      = w;
        waddr   = AW'(wa);
        wdata   = W'(wd);
        re_s[0] = r0;
        ra_s[0] = AW'(a0);
        re_s[1] = r1;
        ra_s[1] = AW'(a1);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re_s[0] = 1'b0; re_s[1] = 1'b0; ra_s[0] = '0; ra_s[1] = '0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // reset clear
        cyc(0, 1, 5, 'hABCDE, 0, 0, 0, 0);
        cyc(1, 1, 6, 'h11111, 1, 5, 1, 5);   // reset wins over concurrent requests
        cyc(0, 0, 0, 0, 1, 5, 0, 0);
        idle();

        // write then read latency, port 1
        cyc(0, 1, 63, 'hFFFFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 63);
        idle();
        idle();

        // read-during-write
        cyc(0, 1, 10, 'h11111, 0, 0, 0, 0);
        cyc(0, 1, 10, 'h22222, 1, 10, 1, 10);
        cyc(0, 0, 0, 0, 1, 10, 0, 0);
        idle();

        // dual-port streaming
        for (int i = 0; i < 8; i++) cyc(0, 1, i, i*3, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, i, 1, 7-i);
        idle();

        // out-of-range on the 40-word unit, then full readback
        cyc(0, 1, 45, 'h12345, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 45, 1, 45);
        for (int i = 0; i < 64; i++) cyc(0, 0, 0, 0, 1, i, 1, 63-i);
        idle();

        // reset mid-read
        cyc(0, 0, 0, 0, 1, 3, 1, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // randomized traffic with biased address collisions
        for (int n = 0; n < 2000; n++) begin
            logic r, w, r0, r1;
            int wa, a0, a1;
            r  = ($urandom_range(0, 99) == 0);
            w  = $urandom_range(0, 1);
            wa = $urandom_range(0, 63);
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            a0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 63));
            a1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a1 = a0;
            cyc(r, w, wa, int'($urandom_range(0, (1 << W) - 1)), r0, a0, r1, a1);
        end
        idle();
        idle();

        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (expq[j].size() != 0) begin
                miscompares++;
                $display("FAIL drain_u%0d_p%0d: got %0d responses outstanding, required 0",
                         j/2, j%2, expq[j].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
